bus_xfer_ctrl: RTL

- Downstream of bus_arbiter: consumes the one-hot grant vector and executes the granted master's transfer on the shared slave bus.
- Latches the winning master's command and runs a burst of 1..16 beats with a valid/ready handshake.
- Returns per-beat ack/read data and a done/error pulse to the owning master.
- Drives bus_busy back to the arbiter so the grant is held for the whole burst.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_xfer_ctrl_if.sv | 37 +++
 rtl/bus_onehot_enc.sv | 20 ++
 rtl/bus_xfer_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: controller state encoding, burst length width and a
// one-hot to index helper reusable by the arbiter.
package bus_pkg;

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   localparam int unsigned LEN_W = 4;

   // OR-reduction encoder; result is only meaningful for a one-hot input.
   function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (oh[i]) idx |= i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Master-side request/response and slave-side bus signals of the transfer
// controller. The master modport is the controller's view.
interface bus_xfer_ctrl_if #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned AW          = 8,
   parameter int unsigned DW          = 8
);
   logic [NUM_MASTERS-1:0]    grant;
   logic [NUM_MASTERS*AW-1:0] m_addr;
   logic [NUM_MASTERS*DW-1:0] m_wdata;
   logic [NUM_MASTERS-1:0]    m_we;
   logic [NUM_MASTERS*4-1:0]  m_len;
   logic [NUM_MASTERS-1:0]    m_ack;
   logic [DW-1:0]             m_rdata;
   logic [NUM_MASTERS-1:0]    m_done;
   logic [NUM_MASTERS-1:0]    m_err;
   logic                      bus_busy;
   logic                      grant_err;
   logic                      s_valid;
   logic [AW-1:0]             s_addr;
   logic                      s_we;
   logic [DW-1:0]             s_wdata;
   logic                      s_ready;
   logic [DW-1:0]             s_rdata;

   modport master (
      input  grant, m_addr, m_wdata, m_we, m_len, s_ready, s_rdata,
      output m_ack, m_rdata, m_done, m_err, bus_busy, grant_err,
             s_valid, s_addr, s_we, s_wdata
   );

   modport slave (
      output grant, m_addr, m_wdata, m_we, m_len, s_ready, s_rdata,
      input  m_ack, m_rdata, m_done, m_err, bus_busy, grant_err,
             s_valid, s_addr, s_we, s_wdata
   );
endinterface

// File: rtl/bus_onehot_enc.sv
// One-hot encoder: index of the set bit, any-bit-set flag, and an exactly-one
// check used to validate grants.
module bus_onehot_enc
   import bus_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  onehot_i,
   output logic [IW-1:0] idx_o,
   output logic          valid_o,
   output logic          onehot_ok_o
);
   logic [31:0] oh_ext;

   assign oh_ext      = 32'(onehot_i);
   assign idx_o       = IW'(onehot_to_idx(oh_ext));
   assign valid_o     = |onehot_i;
   assign onehot_ok_o = valid_o && ((onehot_i & (onehot_i - N'(1))) == '0);
endmodule

// File: rtl/bus_xfer_ctrl.sv
// Executes the granted master's burst on the shared slave bus and reports
// per-beat ack, end-of-burst done and timeout error back to that master.
module bus_xfer_ctrl
   import bus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned AW          = 8,
   parameter int unsigned DW          = 8,
   parameter int unsigned TIMEOUT     = 15
) (
   input  logic             clk,
   input  logic             reset,
   bus_xfer_ctrl_if.master  bus
);
   localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   state_e                 state_q, state_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic                   we_q, we_d;
   logic [7:0]             wait_cnt_q, wait_cnt_d;
   logic                   err_q, err_d;
   logic [NUM_MASTERS-1:0] ack_q, ack_d;
   logic [DW-1:0]          rdata_q, rdata_d;
   logic                   gerr_q, gerr_d;

   logic [IW-1:0]          g_idx;
   logic                   g_valid;
   logic                   g_ok;
   logic [NUM_MASTERS-1:0] owner_oh;

   bus_onehot_enc #(
      .N (NUM_MASTERS)
   ) u_grant_enc (
      .onehot_i    (bus.grant),
      .idx_o       (g_idx),
      .valid_o     (g_valid),
      .onehot_ok_o (g_ok)
   );

   assign owner_oh = NUM_MASTERS'(1) << owner_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         we_q       <= 1'b0;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
         ack_q      <= '0;
         rdata_q    <= '0;
         gerr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         we_q       <= we_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         gerr_q     <= gerr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      len_d      = len_q;
      we_d       = we_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      ack_d      = '0;
      rdata_d    = rdata_q;
      gerr_d     = gerr_q;

      unique case (state_q)
         StIdle: begin
            if (g_ok) begin
               owner_d    = g_idx;
               addr_d     = bus.m_addr[g_idx*AW +: AW];
               len_d      = bus.m_len[g_idx*LEN_W +: LEN_W];
               we_d       = bus.m_we[g_idx];
               wait_cnt_d = '0;
               err_d      = 1'b0;
               state_d    = StXfer;
            end else if (g_valid) begin
               gerr_d = 1'b1;
            end
         end
         StXfer: begin
            if (bus.s_ready) begin
               addr_d     = addr_q + AW'(1);
               wait_cnt_d = '0;
               ack_d      = owner_oh;
               if (!we_q) rdata_d = bus.s_rdata;
               if (len_q == '0) state_d = StDone;
               else             len_d   = len_q - LEN_W'(1);
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               // Abort drops any remaining beats; DONE reports it via m_err.
               if (wait_cnt_d == 8'(TIMEOUT)) begin
                  state_d = StDone;
                  err_d   = 1'b1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.s_valid   = (state_q == StXfer);
      bus.s_addr    = addr_q;
      bus.s_we      = (state_q == StXfer) && we_q;
      bus.s_wdata   = (state_q == StXfer) ? bus.m_wdata[owner_q*DW +: DW] : '0;
      bus.bus_busy  = (state_q != StIdle);
      bus.m_ack     = ack_q;
      bus.m_rdata   = rdata_q;
      bus.m_done    = (state_q == StDone) ? owner_oh : '0;
      bus.m_err     = (state_q == StDone && err_q) ? owner_oh : '0;
      bus.grant_err = gerr_q;
   end
endmodule
